// File: rtl/uvmt_cv32e40x_pma_obi_tracker.sv
// PMA OBI tracker: queues PMA verdicts per accepted address phase until its
// response, and flags bus-level PMA violations as single-cycle pulses.
module uvmt_cv32e40x_pma_obi_tracker #(
    parameter int DEPTH         = 4,
    parameter int IS_INSTR_SIDE = 0,
    parameter int GNT_TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        obi_req_i,
    input  logic        obi_gnt_i,
    input  logic [31:0] obi_addr_i,
    input  logic        obi_we_i,
    input  logic [1:0]  obi_memtype_i,
    input  logic        obi_rvalid_i,
    input  logic        pma_allow_i,
    input  logic        pma_bufferable_i,
    input  logic        pma_cacheable_i,
    output logic [3:0]  outstanding_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_addr_o,
    output logic        resp_we_o,
    output logic        resp_allow_o,
    output logic        resp_bufferable_o,
    output logic        err_blocked_o,
    output logic        err_memtype_o,
    output logic        err_underflow_o,
    output logic        err_overflow_o,
    output logic        err_gnt_timeout_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = (GNT_TIMEOUT > 0) ? $clog2(GNT_TIMEOUT + 1) : 1;
    localparam logic [3:0]    FULL   = 4'(DEPTH);
    localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);
    localparam logic [WW-1:0] TO     = WW'(GNT_TIMEOUT);
    localparam logic [WW-1:0] TO_M1  = WW'(GNT_TIMEOUT - 1);
    localparam logic          WD_EN  = (GNT_TIMEOUT != 0);

    logic [31:0]   r_addr  [DEPTH];
    logic          r_we    [DEPTH];
    logic          r_allow [DEPTH];
    logic          r_buf   [DEPTH];

    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [3:0]    r_cnt;
    logic [WW-1:0] r_wd;

    logic [31:0]   r_h_addr;
    logic          r_h_we;
    logic          r_h_allow;
    logic          r_h_buf;

    logic          r_err_blocked;
    logic          r_err_memtype;
    logic          r_err_underflow;
    logic          r_err_overflow;
    logic          r_err_gnt;

    logic          w_acc;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_empty;
    logic          w_stall;
    logic          w_we;

    assign w_acc   = obi_req_i && obi_gnt_i;
    assign w_empty = (r_cnt == 4'd0);
    assign w_full  = (r_cnt == FULL);
    assign w_pop   = obi_rvalid_i && !w_empty;
    // A full tracker can still take an accept when a response frees a slot
    assign w_push  = w_acc && (!w_full || w_pop);
    assign w_stall = obi_req_i && !obi_gnt_i;
    assign w_we    = (IS_INSTR_SIDE != 0) ? 1'b0 : obi_we_i;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr]  <= obi_addr_i;
            r_we[r_wr]    <= w_we;
            r_allow[r_wr] <= pma_allow_i;
            r_buf[r_wr]   <= pma_bufferable_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr <= (r_wr == LAST) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == LAST) ? '0 : r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 4'd1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Shadow of the head so resp_* keep their last value once the queue drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_addr  <= 32'd0;
            r_h_we    <= 1'b0;
            r_h_allow <= 1'b0;
            r_h_buf   <= 1'b0;
        end else if (!w_empty) begin
            r_h_addr  <= r_addr[r_rd];
            r_h_we    <= r_we[r_rd];
            r_h_allow <= r_allow[r_rd];
            r_h_buf   <= r_buf[r_rd];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd <= '0;
        end else if (!w_stall) begin
            r_wd <= '0;
        end else if (r_wd != TO) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_blocked   <= 1'b0;
            r_err_memtype   <= 1'b0;
            r_err_underflow <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_gnt       <= 1'b0;
        end else begin
            r_err_blocked   <= w_acc && !pma_allow_i;
            r_err_memtype   <= w_acc &&
                (obi_memtype_i != {pma_cacheable_i, pma_bufferable_i});
            r_err_underflow <= obi_rvalid_i && w_empty;
            r_err_overflow  <= w_acc && w_full && !w_pop;
            r_err_gnt       <= WD_EN && w_stall && (r_wd == TO_M1);
        end
    end

    assign outstanding_o     = r_cnt;
    assign resp_valid_o      = !w_empty;
    assign resp_addr_o       = w_empty ? r_h_addr  : r_addr[r_rd];
    assign resp_we_o         = w_empty ? r_h_we    : r_we[r_rd];
    assign resp_allow_o      = w_empty ? r_h_allow : r_allow[r_rd];
    assign resp_bufferable_o = w_empty ? r_h_buf   : r_buf[r_rd];

    assign err_blocked_o     = r_err_blocked;
    assign err_memtype_o     = r_err_memtype;
    assign err_underflow_o   = r_err_underflow;
    assign err_overflow_o    = r_err_overflow;
    assign err_gnt_timeout_o = r_err_gnt;

endmodule
